// File: rtl/alu_muldiv_ctrl_if.sv
// alu_muldiv_ctrl_if
//  Bundles the EX-stage request (instruction, operands, valid, flush) and the
//  registered response/status signals of alu_muldiv_ctrl.
//  Ports carried:
//   i_valid, i_instruction, i_rfile_rs, i_rfile_rt, i_signed_operation, i_flush  (request)
//   o_result, o_alu_zero, o_valid, o_stall, o_busy, o_illegal                   (response)
//  modport master: the pipeline side that issues requests.
//  modport slave : the ALU/mul-div control block.
interface alu_muldiv_ctrl_if #(
  parameter int NB_DATA = 32
);
  logic               i_valid;
  logic [NB_DATA-1:0] i_instruction;
  logic [NB_DATA-1:0] i_rfile_rs;
  logic [NB_DATA-1:0] i_rfile_rt;
  logic               i_signed_operation;
  logic               i_flush;
  logic [NB_DATA-1:0] o_result;
  logic               o_alu_zero;
  logic               o_valid;
  logic               o_stall;
  logic               o_busy;
  logic               o_illegal;

  modport master (
    output i_valid, i_instruction, i_rfile_rs, i_rfile_rt, i_signed_operation, i_flush,
    input  o_result, o_alu_zero, o_valid, o_stall, o_busy, o_illegal
  );

  modport slave (
    input  i_valid, i_instruction, i_rfile_rs, i_rfile_rt, i_signed_operation, i_flush,
    output o_result, o_alu_zero, o_valid, o_stall, o_busy, o_illegal
  );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl
//  EX-stage ALU control: decodes the R-type funct/shamt fields, executes
//  single-cycle ALU ops with a registered result, and runs an iterative
//  shift-add multiplier / restoring divider that writes HI/LO.
//  Ports:
//   i_clock   rising-edge clock
//   i_reset_n asynchronous active-low reset
//   bus       alu_muldiv_ctrl_if.slave (request in, result/status out)
module alu_muldiv_ctrl #(
  parameter int NB_DATA        = 32,
  parameter int NB_ADDR        = $clog2(NB_DATA),
  parameter int NB_CTRL_OPCODE = 6
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  alu_muldiv_ctrl_if.slave bus
);
  typedef logic [NB_CTRL_OPCODE-1:0] funct_t;
  localparam funct_t F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04;
  localparam funct_t F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08;
  localparam funct_t F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam funct_t F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam funct_t F_ADD  = 6'h21, F_SUB  = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25;
  localparam funct_t F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [NB_ADDR-1:0] LAST_STEP = NB_ADDR'(NB_DATA - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  state_t               state_reg, state_next;
  logic [NB_ADDR-1:0]   cnt_reg, cnt_next;
  logic [2*NB_DATA-1:0] acc_reg, acc_next;     // mul: {hi, multiplier}; div: {remainder, dividend/quotient}
  logic [NB_DATA-1:0]   opnd_reg, opnd_next;   // multiplicand or divisor
  logic                 is_div_reg, is_div_next;
  logic                 neg_lo_reg, neg_lo_next; // negate product / quotient in FIX
  logic                 neg_hi_reg, neg_hi_next; // negate remainder in FIX
  logic [NB_DATA-1:0]   hi_reg, hi_next, lo_reg, lo_next;
  logic [NB_DATA-1:0]   result_reg, result_next;
  logic                 zero_reg, zero_next, valid_reg, valid_next, illegal_reg, illegal_next;

  // Decode
  funct_t             funct;
  logic [NB_ADDR-1:0] shamt;
  logic [NB_DATA-1:0] rs, rt;
  logic               is_mul, is_div, is_hilo, busy, stall, accept;
  logic               unused_instr_bits;

  assign funct   = bus.i_instruction[NB_CTRL_OPCODE-1:0];
  assign shamt   = bus.i_instruction[NB_CTRL_OPCODE +: NB_ADDR];
  assign rs      = bus.i_rfile_rs;
  assign rt      = bus.i_rfile_rt;
  assign unused_instr_bits = ^bus.i_instruction[NB_DATA-1:NB_CTRL_OPCODE+NB_ADDR];
  assign is_mul  = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div  = (funct == F_DIV) || (funct == F_DIVU);
  assign is_hilo = is_mul || is_div || (funct == F_MFHI) || (funct == F_MFLO)
                   || (funct == F_MTHI) || (funct == F_MTLO);
  assign busy    = (state_reg != ST_IDLE);
  // Only HI/LO users wait on the engine; everything else overlaps with it.
  assign stall   = busy && bus.i_valid && is_hilo;
  assign accept  = bus.i_valid && !stall && !bus.i_flush;

  // Single-cycle ALU
  logic [NB_DATA-1:0] alu_value;
  logic               illegal_op, slt_bit;

  assign slt_bit = bus.i_signed_operation ? ($signed(rs) < $signed(rt)) : (rs < rt);

  always_comb begin
    alu_value  = '0;
    illegal_op = 1'b0;
    case (funct)
      F_SLL:  alu_value = rt << shamt;
      F_SRL:  alu_value = rt >> shamt;
      F_SRA:  alu_value = $unsigned($signed(rt) >>> shamt);
      F_SLLV: alu_value = rt << rs[NB_ADDR-1:0];
      F_SRLV: alu_value = rt >> rs[NB_ADDR-1:0];
      F_SRAV: alu_value = $unsigned($signed(rt) >>> rs[NB_ADDR-1:0]);
      F_ADD:  alu_value = rs + rt;
      F_SUB:  alu_value = rs - rt;
      F_AND:  alu_value = rs & rt;
      F_OR:   alu_value = rs | rt;
      F_XOR:  alu_value = rs ^ rt;
      F_NOR:  alu_value = ~(rs | rt);
      F_SLT:  alu_value = {{(NB_DATA-1){1'b0}}, slt_bit};
      F_SLTU: alu_value = {{(NB_DATA-1){1'b0}}, (rs < rt)};
      F_MFHI: alu_value = hi_reg;
      F_MFLO: alu_value = lo_reg;
      F_MTHI, F_MTLO: alu_value = rs;
      F_JR, F_MULT, F_MULTU, F_DIV, F_DIVU: alu_value = '0;
      default: illegal_op = 1'b1;
    endcase
  end

  // Mul/div operand preparation and one iteration step
  logic                 sgn_op, rs_neg, rt_neg, rt_zero;
  logic [NB_DATA-1:0]   abs_rs, abs_rt;
  logic [NB_DATA:0]     mul_sum, div_shift, div_diff;
  logic                 div_ge;
  logic [2*NB_DATA-1:0] mul_step, div_step, product_fixed;
  logic [NB_DATA-1:0]   quo_fixed, rem_fixed;

  assign sgn_op  = (funct == F_MULT) || (funct == F_DIV);
  assign rs_neg  = sgn_op && rs[NB_DATA-1];
  assign rt_neg  = sgn_op && rt[NB_DATA-1];
  assign rt_zero = (rt == '0);
  assign abs_rs  = rs_neg ? -rs : rs;
  assign abs_rt  = rt_neg ? -rt : rt;

  assign mul_sum   = {1'b0, acc_reg[2*NB_DATA-1:NB_DATA]} + {1'b0, (acc_reg[0] ? opnd_reg : '0)};
  assign mul_step  = {mul_sum, acc_reg[NB_DATA-1:1]};
  assign div_shift = {acc_reg[2*NB_DATA-1:NB_DATA], acc_reg[NB_DATA-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_reg});
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_step  = div_ge ? {div_diff[NB_DATA-1:0], acc_reg[NB_DATA-2:0], 1'b1}
                            : {div_shift[NB_DATA-1:0], acc_reg[NB_DATA-2:0], 1'b0};

  assign product_fixed = neg_lo_reg ? -acc_reg : acc_reg;
  assign quo_fixed     = neg_lo_reg ? -acc_reg[NB_DATA-1:0] : acc_reg[NB_DATA-1:0];
  assign rem_fixed     = neg_hi_reg ? -acc_reg[2*NB_DATA-1:NB_DATA] : acc_reg[2*NB_DATA-1:NB_DATA];

  // Next-state and datapath next values
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    acc_next     = acc_reg;
    opnd_next    = opnd_reg;
    is_div_next  = is_div_reg;
    neg_lo_next  = neg_lo_reg;
    neg_hi_next  = neg_hi_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    result_next  = result_reg;
    zero_next    = zero_reg;
    valid_next   = 1'b0;
    illegal_next = 1'b0;

    if (accept && !is_mul && !is_div) begin
      result_next  = alu_value;
      zero_next    = (alu_value == '0);
      valid_next   = 1'b1;
      illegal_next = illegal_op;
      if (funct == F_MTHI) hi_next = rs;
      if (funct == F_MTLO) lo_next = rs;
    end

    if (bus.i_flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept && (is_mul || is_div)) begin
            state_next  = is_div ? ST_DIV : ST_MUL;
            cnt_next    = '0;
            is_div_next = is_div;
            opnd_next   = is_div ? abs_rt : abs_rs;
            acc_next    = {{NB_DATA{1'b0}}, (is_div ? abs_rs : abs_rt)};
            // Divide by zero keeps the all-ones quotient unsigned-looking.
            neg_lo_next = (rs_neg ^ rt_neg) && !(is_div && rt_zero);
            neg_hi_next = rs_neg;
          end
        end
        ST_MUL: begin
          acc_next = mul_step;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) state_next = ST_FIX;
        end
        ST_DIV: begin
          acc_next = div_step;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) state_next = ST_FIX;
        end
        ST_FIX: begin
          if (is_div_reg) begin
            hi_next = rem_fixed;
            lo_next = quo_fixed;
          end else begin
            {hi_next, lo_next} = product_fixed;
          end
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      is_div_reg  <= 1'b0;
      neg_lo_reg  <= 1'b0;
      neg_hi_reg  <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b1;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      acc_reg     <= acc_next;
      opnd_reg    <= opnd_next;
      is_div_reg  <= is_div_next;
      neg_lo_reg  <= neg_lo_next;
      neg_hi_reg  <= neg_hi_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
      valid_reg   <= valid_next;
      illegal_reg <= illegal_next;
    end
  end

  assign bus.o_result   = result_reg;
  assign bus.o_alu_zero = zero_reg;
  assign bus.o_valid    = valid_reg;
  assign bus.o_stall    = stall;
  assign bus.o_busy     = busy;
  assign bus.o_illegal  = illegal_reg;
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb_alu_muldiv_ctrl
//  Self-checking bench for alu_muldiv_ctrl: directed ALU cases, a random
//  back-to-back stream, mul/div results and timing, flush, illegal funct and
//  asynchronous reset. Expected ALU results go through a scoreboard queue.
module tb_alu_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_muldiv_ctrl_if #(.NB_DATA(32)) bus ();
  alu_muldiv_ctrl #(.NB_DATA(32)) dut (.i_clock(clk), .i_reset_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q [$];

  localparam logic [5:0] SLL = 6'h00, SRL = 6'h02, SRA = 6'h03, SLLV = 6'h04, SRLV = 6'h06, SRAV = 6'h07;
  localparam logic [5:0] JR = 6'h08, MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;
  localparam logic [5:0] ADD = 6'h21, SUB = 6'h23, AND_ = 6'h24, OR_ = 6'h25, XOR_ = 6'h26, NOR_ = 6'h27;
  localparam logic [5:0] SLT = 6'h2A, SLTU = 6'h2B;

  // Reference ALU written independently of the RTL structure.
  function automatic logic [31:0] alu_model(input logic [5:0] f, input logic [4:0] sh,
                                            input logic [31:0] rs, input logic [31:0] rt);
    logic [63:0] ext;
    logic [4:0]  amt;
    amt = (f == SLLV || f == SRLV || f == SRAV) ? rs[4:0] : sh;
    ext = {{32{rt[31]}}, rt} >> amt;
    case (f)
      SLL, SLLV: return rt << amt;
      SRL, SRLV: return rt >> amt;
      SRA, SRAV: return ext[31:0];
      ADD:  return rs + rt;
      SUB:  return rs + ~rt + 32'd1;
      AND_: return rs & rt;
      OR_:  return rs | rt;
      XOR_: return rs ^ rt;
      NOR_: return ~(rs | rt);
      SLT:  return ((rs[31] != rt[31]) ? {31'd0, rs[31]} : {31'd0, rs < rt});
      SLTU: return {31'd0, rs < rt};
      default: return 32'd0;
    endcase
  endfunction

  // Presents one request for one clock; returns 1 time unit after the edge.
  task automatic drive(input logic v, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic fl);
    bus.i_valid = v;
    bus.i_instruction = {21'd0, sh, f};
    bus.i_rfile_rs = rs;
    bus.i_rfile_rt = rt;
    bus.i_signed_operation = 1'b1;
    bus.i_flush = fl;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo, output logic ok);
    logic vh;
    drive(1'b1, MFHI, 5'd0, 32'd0, 32'd0, 1'b0);
    hi = bus.o_result;
    vh = bus.o_valid;
    drive(1'b1, MFLO, 5'd0, 32'd0, 32'd0, 1'b0);
    lo = bus.o_result;
    ok = vh && bus.o_valid;
  endtask

  // Starts a mul/div and counts cycles until o_busy falls (bounded).
  task automatic run_muldiv(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                            output int cycles);
    drive(1'b1, f, 5'd0, rs, rt, 1'b0);
    cycles = 0;
    while (bus.o_busy && cycles < 200) begin
      cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] hi, lo;
    logic ok;
    n_cmp++; if (bus.o_result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h want 00000000", bus.o_result); end
    n_cmp++; if (bus.o_alu_zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero: got %b want 1", bus.o_alu_zero); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %b want 0", bus.o_illegal); end
    rst_n = 1'b1;
    read_hilo(hi, lo, ok);
    n_cmp++; if (!ok || hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL reset_hilo: got ok=%b hi=%h lo=%h want 1 0 0", ok, hi, lo); end
  endtask

  task automatic test_alu;
    logic [5:0]  f  [10] = '{ADD, SUB, SRA, SLL, SRLV, SRAV, SLT, SLTU, NOR_, SUB};
    logic [4:0]  sh [10] = '{5'd0, 5'd0, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] rs [10] = '{32'h7FFFFFFF, 32'd5, 32'd0, 32'd0, 32'h24, 32'h1F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] rt [10] = '{32'd1, 32'd5, 32'h80000000, 32'd1, 32'hF0000000, 32'h80000000, 32'd1, 32'd1, 32'd0, 32'd1};
    logic [31:0] ex [10] = '{32'h80000000, 32'd0, 32'hF8000000, 32'h80000000, 32'h0F000000, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e, last;
    last = 32'd0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(ex[i]);
      drive(1'b1, f[i], sh[i], rs[i], rt[i], 1'b0);
      e = exp_q.pop_front();
      last = e;
      n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL alu_valid[%0d]: got %b want 1", i, bus.o_valid); end
      n_cmp++; if (bus.o_result !== e) begin n_bad++; $display("FAIL alu_result[%0d] funct=%h: got %h want %h", i, f[i], bus.o_result, e); end
      n_cmp++; if (bus.o_alu_zero !== (e == 32'd0)) begin n_bad++; $display("FAIL alu_zero[%0d]: got %b want %b", i, bus.o_alu_zero, (e == 32'd0)); end
    end
    idle(1);
    n_cmp++; if (bus.o_valid !== 1'b0 || bus.o_result !== last) begin n_bad++; $display("FAIL alu_hold: got valid=%b result=%h want 0 %h", bus.o_valid, bus.o_result, last); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] ops [14] = '{SLL, SRL, SRA, SLLV, SRLV, SRAV, ADD, SUB, AND_, OR_, XOR_, NOR_, SLT, SLTU};
    logic [5:0]  f;
    logic [4:0]  sh;
    logic [31:0] rs, rt, e;
    for (int i = 0; i < 24; i++) begin
      f  = ops[$urandom_range(0, 13)];
      sh = 5'($urandom_range(0, 31));
      rs = $urandom;
      rt = (i % 5 == 0) ? rs : $urandom;
      exp_q.push_back(alu_model(f, sh, rs, rt));
      drive(1'b1, f, sh, rs, rt, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.o_valid !== 1'b1 || bus.o_result !== e || bus.o_alu_zero !== (e == 32'd0)) begin
        n_bad++;
        $display("FAIL b2b[%0d] funct=%h rs=%h rt=%h sh=%0d: got v=%b r=%h z=%b want 1 %h %b",
                 i, f, rs, rt, sh, bus.o_valid, bus.o_result, bus.o_alu_zero, e, (e == 32'd0));
      end
    end
  endtask

  task automatic test_mul_stall;
    int stalls;
    logic [31:0] hi;
    drive(1'b1, MULT, 5'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
    n_cmp++; if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL mult_start: got valid=%b busy=%b want 0 1", bus.o_valid, bus.o_busy); end
    bus.i_valid = 1'b1;
    bus.i_instruction = {26'd0, MFLO};
    #1;
    stalls = 0;
    while (bus.o_stall && stalls < 100) begin
      stalls++;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (stalls != 33) begin n_bad++; $display("FAIL mult_stall_cycles: got %0d want 33", stalls); end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    n_cmp++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mult_lo: got v=%b %h want 1 ffffffeb", bus.o_valid, bus.o_result); end
    drive(1'b1, MFHI, 5'd0, 32'd0, 32'd0, 1'b0);
    hi = bus.o_result;
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
  endtask

  task automatic test_muldiv;
    logic [5:0]  f   [7] = '{DIV, DIVU, DIV, MULTU, DIV, DIV, MULT};
    logic [31:0] rs  [7] = '{32'hFFFFFFF9, 32'd9, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF7, 32'd7, 32'h80000000};
    logic [31:0] rt  [7] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, 32'h80000000};
    logic [31:0] ehi [7] = '{32'hFFFFFFFF, 32'd9, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFF7, 32'd1, 32'h40000000};
    logic [31:0] elo [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd0};
    int cyc;
    logic [31:0] hi, lo;
    logic ok;
    for (int i = 0; i < 7; i++) begin
      run_muldiv(f[i], rs[i], rt[i], cyc);
      n_cmp++; if (cyc != 33) begin n_bad++; $display("FAIL muldiv_busy[%0d]: got %0d cycles want 33", i, cyc); end
      read_hilo(hi, lo, ok);
      n_cmp++;
      if (!ok || hi !== ehi[i] || lo !== elo[i]) begin
        n_bad++;
        $display("FAIL muldiv[%0d] funct=%h rs=%h rt=%h: got ok=%b hi=%h lo=%h want 1 %h %h",
                 i, f[i], rs[i], rt[i], ok, hi, lo, ehi[i], elo[i]);
      end
    end
  endtask

  task automatic test_overlap;
    logic [31:0] e, hi, lo;
    logic ok;
    int cyc;
    drive(1'b1, DIVU, 5'd0, 32'd100, 32'd7, 1'b0);
    idle(3);
    exp_q.push_back(32'd5);
    drive(1'b1, ADD, 5'd0, 32'd2, 32'd3, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (bus.o_valid !== 1'b1 || bus.o_result !== e || bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL overlap_add: got v=%b r=%h busy=%b want 1 %h 1", bus.o_valid, bus.o_result, bus.o_busy, e); end
    cyc = 0;
    while (bus.o_busy && cyc < 200) begin cyc++; @(posedge clk); #1; end
    read_hilo(hi, lo, ok);
    n_cmp++; if (!ok || hi !== 32'd2 || lo !== 32'd14) begin n_bad++; $display("FAIL overlap_divu: got ok=%b hi=%h lo=%h want 1 2 e", ok, hi, lo); end
  endtask

  task automatic test_flush;
    logic [31:0] hi, lo;
    logic ok;
    drive(1'b1, MTHI, 5'd0, 32'h12345678, 32'd0, 1'b0);
    n_cmp++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'h12345678) begin n_bad++; $display("FAIL mthi_out: got v=%b %h want 1 12345678", bus.o_valid, bus.o_result); end
    drive(1'b1, MTLO, 5'd0, 32'h9ABCDEF0, 32'd0, 1'b0);
    drive(1'b1, MULTU, 5'd0, 32'd5, 32'd6, 1'b0);
    idle(8);
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL flush_prebusy: got %b want 1", bus.o_busy); end
    drive(1'b1, ADD, 5'd0, 32'd1, 32'd1, 1'b1);
    n_cmp++; if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL flush_state: got busy=%b valid=%b want 0 0", bus.o_busy, bus.o_valid); end
    read_hilo(hi, lo, ok);
    n_cmp++; if (!ok || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin n_bad++; $display("FAIL flush_hilo: got ok=%b hi=%h lo=%h want 1 12345678 9abcdef0", ok, hi, lo); end
  endtask

  task automatic test_illegal;
    drive(1'b1, ADD, 5'd0, 32'd1, 32'd1, 1'b0);
    drive(1'b1, 6'h3F, 5'd0, 32'd1, 32'd1, 1'b0);
    n_cmp++; if (bus.o_illegal !== 1'b1 || bus.o_valid !== 1'b1 || bus.o_result !== 32'd0 || bus.o_alu_zero !== 1'b1) begin n_bad++; $display("FAIL illegal_3f: got ill=%b v=%b r=%h z=%b want 1 1 0 1", bus.o_illegal, bus.o_valid, bus.o_result, bus.o_alu_zero); end
    idle(1);
    n_cmp++; if (bus.o_illegal !== 1'b0 || bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL illegal_pulse: got ill=%b v=%b want 0 0", bus.o_illegal, bus.o_valid); end
    drive(1'b1, ADD, 5'd0, 32'd4, 32'd4, 1'b0);
    drive(1'b1, JR, 5'd0, 32'd4, 32'd4, 1'b0);
    n_cmp++; if (bus.o_illegal !== 1'b0 || bus.o_valid !== 1'b1 || bus.o_result !== 32'd0) begin n_bad++; $display("FAIL jr: got ill=%b v=%b r=%h want 0 1 0", bus.o_illegal, bus.o_valid, bus.o_result); end
  endtask

  task automatic test_async_reset;
    logic [31:0] hi, lo;
    logic ok;
    drive(1'b1, MTHI, 5'd0, 32'hAAAA5555, 32'd0, 1'b0);
    drive(1'b1, ADD, 5'd0, 32'd3, 32'd4, 1'b0);
    drive(1'b1, DIV, 5'd0, 32'd100, 32'd3, 1'b0);
    idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_result !== 32'd0 || bus.o_alu_zero !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got busy=%b r=%h z=%b v=%b ill=%b want 0 0 1 0 0", bus.o_busy, bus.o_result, bus.o_alu_zero, bus.o_valid, bus.o_illegal);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    read_hilo(hi, lo, ok);
    n_cmp++; if (!ok || hi !== 32'd0 || lo !== 32'd0) begin n_bad++; $display("FAIL async_reset_hilo: got ok=%b hi=%h lo=%h want 1 0 0", ok, hi, lo); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_instruction = 32'd0;
    bus.i_rfile_rs = 32'd0;
    bus.i_rfile_rt = 32'd0;
    bus.i_signed_operation = 1'b1;
    bus.i_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_alu;
    test_back_to_back;
    test_mul_stall;
    test_muldiv;
    test_overlap;
    test_flush;
    test_illegal;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
